// File: rtl/seq_mag_cmp_if.sv
// Request/response bundle for the sequential magnitude comparator.
// The master issues start with operands; the slave reports busy/done and relation flags.
interface seq_mag_cmp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       mode;
  logic             sgn;
  logic             busy;
  logic             done;
  logic             result;
  logic             agtb;
  logic             aeqb;
  logic             altb;

  modport master (
    output start, a, b, mode, sgn,
    input  busy, done, result, agtb, aeqb, altb
  );

  modport slave (
    input  start, a, b, mode, sgn,
    output busy, done, result, agtb, aeqb, altb
  );
endinterface

// File: rtl/seq_mag_cmp.sv
// Multi-cycle magnitude comparator: scans GROUP_W bits per clock MSB-first,
// exits at the first unequal group, and reports one of six relations.
module seq_mag_cmp #(
  parameter int WIDTH   = 8,
  parameter int GROUP_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mag_cmp_if.slave   cmp
);
  localparam int NG   = WIDTH / GROUP_W;
  localparam int IDXW = (NG > 1) ? $clog2(NG) : 1;
  // Flipping the MSB maps two's complement onto offset binary, so the
  // unsigned scan below yields the signed ordering.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  sa_reg;
  logic [WIDTH-1:0]  sb_reg;
  logic [2:0]        mode_reg;
  logic [IDXW-1:0]   idx_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              result_reg;
  logic              agtb_reg;
  logic              aeqb_reg;
  logic              altb_reg;

  logic [GROUP_W-1:0] grp_a [NG];
  logic [GROUP_W-1:0] grp_b [NG];

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_split
      assign grp_a[gi] = sa_reg[gi*GROUP_W +: GROUP_W];
      assign grp_b[gi] = sb_reg[gi*GROUP_W +: GROUP_W];
    end
  endgenerate

  logic [GROUP_W-1:0] ga;
  logic [GROUP_W-1:0] gb;
  logic               diff;
  logic               finish;
  logic               gt_next;
  logic               eq_next;
  logic               lt_next;
  logic               rel_next;

  always_comb begin
    ga       = grp_a[idx_reg];
    gb       = grp_b[idx_reg];
    diff     = (ga != gb);
    finish   = (state_reg == SCAN) && (diff || (idx_reg == '0));
    gt_next  = diff && (ga > gb);
    eq_next  = !diff;
    lt_next  = diff && !(ga > gb);
    rel_next = 1'b0;
    case (mode_reg)
      3'b000:  rel_next = eq_next;
      3'b001:  rel_next = !eq_next;
      3'b010:  rel_next = gt_next;
      3'b011:  rel_next = gt_next || eq_next;
      3'b100:  rel_next = lt_next;
      3'b101:  rel_next = lt_next || eq_next;
      default: rel_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      mode_reg   <= '0;
      idx_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= 1'b0;
      agtb_reg   <= 1'b0;
      aeqb_reg   <= 1'b0;
      altb_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmp.start) begin
            sa_reg    <= cmp.a ^ (cmp.sgn ? MSB_MASK : '0);
            sb_reg    <= cmp.b ^ (cmp.sgn ? MSB_MASK : '0);
            mode_reg  <= cmp.mode;
            idx_reg   <= IDXW'(NG - 1);
            busy_reg  <= 1'b1;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (finish) begin
            agtb_reg   <= gt_next;
            aeqb_reg   <= eq_next;
            altb_reg   <= lt_next;
            result_reg <= rel_next;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmp.busy   = busy_reg;
  assign cmp.done   = done_reg;
  assign cmp.result = result_reg;
  assign cmp.agtb   = agtb_reg;
  assign cmp.aeqb   = aeqb_reg;
  assign cmp.altb   = altb_reg;
endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed bench for seq_mag_cmp: an 8-bit/2-bit instance and a 16-bit/4-bit instance.
// Flags are compared packed as {result, agtb, aeqb, altb}.
module tb_seq_mag_cmp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mag_cmp_if #(.WIDTH(8))  if8 ();
  seq_mag_cmp_if #(.WIDTH(16)) if16 ();

  seq_mag_cmp #(.WIDTH(8),  .GROUP_W(2)) u_cmp8  (.clk(clk), .rst_n(rst_n), .cmp(if8));
  seq_mag_cmp #(.WIDTH(16), .GROUP_W(4)) u_cmp16 (.clk(clk), .rst_n(rst_n), .cmp(if16));

  localparam logic [2:0] M_EQ = 3'b000, M_NE = 3'b001, M_GT = 3'b010,
                         M_GE = 3'b011, M_LT = 3'b100, M_LE = 3'b101, M_RSV = 3'b110;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  function automatic int flags(input bit w16);
    if (w16) return int'({if16.result, if16.agtb, if16.aeqb, if16.altb});
    return int'({if8.result, if8.agtb, if8.aeqb, if8.altb});
  endfunction

  function automatic bit is_done(input bit w16);
    return w16 ? if16.done : if8.done;
  endfunction

  function automatic bit is_busy(input bit w16);
    return w16 ? if16.busy : if8.busy;
  endfunction

  task automatic drive(input bit w16, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] m, input logic s);
    if (w16) begin
      if16.start = st; if16.a = a; if16.b = b; if16.mode = m; if16.sgn = s;
    end else begin
      if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.mode = m; if8.sgn = s;
    end
  endtask

  // Leaves the bench at the negedge following the accepting edge.
  task automatic launch(input string tag, input bit w16, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] m, input logic s);
    @(negedge clk);
    drive(w16, 1'b1, a, b, m, s);
    @(negedge clk);
    drive(w16, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
    chk({tag, "_busy"}, int'(is_busy(w16)), 1);
  endtask

  // Counts scan edges until done; leaves the bench in the done cycle.
  task automatic wait_done(input string tag, input bit w16, output int n);
    n = 0;
    while (!is_done(w16) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!is_done(w16)) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run(input string tag, input bit w16, input logic [15:0] a,
                     input logic [15:0] b, input logic [2:0] m, input logic s,
                     input int exp_n, input int exp_f);
    int n;
    launch(tag, w16, a, b, m, s);
    wait_done(tag, w16, n);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_flg"}, flags(w16), exp_f);
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 3'b000, 1'b0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle8_%0d", i),
          int'({if8.busy, if8.done, if8.result, if8.agtb, if8.aeqb, if8.altb}), 0);
    end
    chk("idle16", int'({if16.busy, if16.done, flags(1'b1)}), 0);

    run("ge_early", 1'b0, 16'h00C0, 16'h003F, M_GE, 1'b0, 1, 4'b1100);
    @(negedge clk);
    chk("done_pulse", int'(if8.done), 0);
    chk("flags_hold", flags(1'b0), 4'b1100);

    run("ge_eq",   1'b0, 16'h005A, 16'h005A, M_GE, 1'b0, 4, 4'b1010);
    run("ne_eq",   1'b0, 16'h005A, 16'h005A, M_NE, 1'b0, 4, 4'b0010);
    run("lt_sgn",  1'b0, 16'h0080, 16'h0001, M_LT, 1'b1, 1, 4'b1001);
    run("lt_uns",  1'b0, 16'h0080, 16'h0001, M_LT, 1'b0, 1, 4'b0100);
    run("gt_lsb",  1'b0, 16'h0003, 16'h0002, M_GT, 1'b0, 4, 4'b1100);
    run("le_sgn",  1'b0, 16'h00FF, 16'h00FE, M_LE, 1'b1, 4, 4'b0100);
    run("rsv",     1'b0, 16'h0001, 16'h0002, M_RSV, 1'b0, 4, 4'b0001);

    // A start pulse mid-scan must be neither taken nor queued.
    launch("ign", 1'b0, 16'h005A, 16'h005A, M_EQ, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h00FF, 16'h0000, M_NE, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0);
    wait_done("ign", 1'b0, n);
    chk("ign_lat", n, 2);
    chk("ign_flg", flags(1'b0), 4'b1010);
    @(negedge clk);
    chk("ign_noq", int'({if8.busy, if8.done}), 0);

    // Back-to-back: new start presented in the done cycle.
    launch("b2b_a", 1'b0, 16'h00C0, 16'h003F, M_LT, 1'b0);
    wait_done("b2b_a", 1'b0, n);
    chk("b2b_a_flg", flags(1'b0), 4'b0100);
    drive(1'b0, 1'b1, 16'h0001, 16'h0002, M_LE, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0);
    chk("b2b_busy", int'({if8.busy, if8.done}), 2);
    wait_done("b2b_b", 1'b0, n);
    chk("b2b_b_lat", n, 4);
    chk("b2b_b_flg", flags(1'b0), 4'b1001);

    // Reset during an equal-operand scan aborts it and clears the flags.
    launch("rst", 1'b0, 16'h005A, 16'h005A, M_GE, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_clr", int'({if8.busy, if8.done, flags(1'b0)}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_nodone", int'(if8.done), 0);
    run("post_rst", 1'b0, 16'h0012, 16'h0034, M_GT, 1'b0, 2, 4'b0001);

    run("w16_le",  1'b1, 16'h1234, 16'h1235, M_LE, 1'b0, 4, 4'b1001);
    run("w16_sgn", 1'b1, 16'h8000, 16'h7FFF, M_GT, 1'b1, 1, 4'b0001);
    run("w16_eq",  1'b1, 16'hBEEF, 16'hBEEF, M_EQ, 1'b0, 4, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
